bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shared-bus arbiter and address/data multiplexer for the system bus.
//  - Responder side of the breq_/bgrt_ handshake used by the DMA controller, CPU and other bus masters.
//  - Grants one master at a time in round-robin order.
//  - Routes the owner's addr/odata/rw_ onto the shared memory/I-O bus.
//  - Drives the bus to a quiet default when no master owns it.
// PARAMETERS
//  N_MASTERS   4                 number of requesting masters (2..8)
//  IDX_W       2                 width of owner index, = clog2(N_MASTERS)
//  ADDR_W      `BUS_ADDR_WIDTH   bus address width
//  DATA_W      `DATA_WIDTH       bus data width
//  MAX_HOLD    256               tenure cycles after which hold_ovf is flagged (>=2)
// PORTS
//  clk       in   1                 rising-edge clock
//  reset     in   1                 synchronous, active-high reset
//  breq_     in   N_MASTERS         per-master bus request, active-low (`Enable_)
//  bgrt_     out  N_MASTERS         per-master bus grant, active-low, registered, one-hot-low or all high
//  m_addr    in   N_MASTERS*ADDR_W  master addresses, master i at [i*ADDR_W +: ADDR_W]
//  m_odata   in   N_MASTERS*DATA_W  master write data, packed as m_addr
//  m_rw_     in   N_MASTERS         master read/write (`Read / `Write)
//  addr      out  ADDR_W            shared bus address
//  odata     out  DATA_W            shared bus write data
//  rw_       out  1                 shared bus read/write
//  owner     out  IDX_W             index of current owner, valid when bus_busy
//  bus_busy  out  1                 high while a grant is held
//  hold_ovf  out  1                 owner has held the bus >= MAX_HOLD cycles
// BEHAVIOUR
//  - Reset values (next edge with reset=1, regardless of state):
//    bgrt_ = all 1, owner = 0, bus_busy = 0, hold_ovf = 0, hold_cnt = 0,
//    rr_ptr = 0, state = IDLE.
//    A grant in progress is withdrawn at that edge.
//  - States:
//    IDLE: no grant.
//      If any breq_ bit is low, pick the winner and go to GRANT.
//      Winner = first requesting index scanning rr_ptr, rr_ptr+1, ... mod N_MASTERS.
//      Registered at that edge: bgrt_[w] = 0, owner = w, bus_busy = 1, hold_cnt = 0.
//    GRANT: hold the grant while breq_[owner] = 0.
//      - Requests from other masters are ignored (no preemption).
//      - When breq_[owner] is sampled 1, go to RELEASE. At that edge bgrt_ = all 1, bus_busy = 0,
//        hold_ovf = 0, rr_ptr = owner+1 (mod N_MASTERS).
//    RELEASE: one dead cycle with no grant (bus turnaround), then unconditionally to IDLE.
//  - Latency:
//    - breq_ sampled low in IDLE at edge k -> bgrt_ low after edge k.
//    - Release sampled at edge k -> the next grant is issued no earlier than edge k+2.
//  - Bus mux (combinational from owner/bus_busy):
//    - When bus_busy = 1: addr/odata/rw_ = m_addr/m_odata/m_rw_ of owner.
//    - Otherwise: addr = 0, odata = 0, rw_ = `Read.
//    - The bus never carries `Write while un-owned.
//  - Tenure counter:
//    - hold_cnt increments each GRANT cycle, saturating at MAX_HOLD.
//    - hold_ovf is registered; it goes high the edge hold_cnt reaches MAX_HOLD.
//    - hold_ovf stays high until release or reset. It is advisory only; the grant is not revoked.
//  - Boundary cases:
//    - Simultaneous requests: round-robin order decides.
//    - A request deasserted in the same cycle it would win: it is not granted, because the
//      winner is computed from the sampled breq_.
//    - rr_ptr wraps from N_MASTERS-1 to 0.
//    - All masters requesting continuously: each is served once per N_MASTERS tenures.
//    - A master reasserting breq_ during RELEASE competes normally in IDLE. It does not win
//      automatically; its rr_ptr position has already advanced past it.
//    - Invalid index bits beyond N_MASTERS (non-power-of-2) are never selected.
// STRUCTURE
//  - Shared defines header (existing): `Enable_, `Disable_, `Read, `Write, `BUS_ADDR_WIDTH,
//    `DATA_WIDTH.
//  - New in the header: `ARB_IDLE, `ARB_GRANT, `ARB_RELEASE (2-bit state codes).
//  - One sub-module, rr_pick:
//    - Combinational round-robin priority selector.
//    - Inputs: req (active-high, N_MASTERS), ptr (IDX_W).
//    - Outputs: valid, idx.
//  - Top level holds the FSM, registered grant/owner, tenure counter and output mux.
// TESTING
//  1. Reset:
//     - Assert reset mid-GRANT of master 2.
//     - Next edge: bgrt_=4'b1111, bus_busy=0, rw_=`Read, addr=0. After reset, master 0
//       requesting alone is granted first.
//  2. Single master:
//     - breq_=4'b1101 at edge k -> bgrt_=4'b1101 after k, owner=1.
//     - Bus shows m_addr[1] (e.g. 'h0040) with rw_=`Write.
//     - Release -> RELEASE -> IDLE.
//  3. Round-robin:
//     - All four requesting continuously, each holding 3 cycles.
//     - Grant order 0,1,2,3,0.
//     - Exactly one dead cycle plus one idle cycle between tenures.
//  4. Wrap and skip:
//     - rr_ptr=3 with only masters 3 and 1 requesting -> 3 wins.
//     - Next: 1 wins, then rr_ptr=2.
//  5. No preemption and hold_ovf:
//     - With MAX_HOLD=8, master 0 holds 10 cycles while master 3 requests.
//     - hold_ovf rises after the 8th grant cycle.
//     - bgrt_[3] stays 1 until master 0 releases, then master 3 is granted 2 edges after release.
//  6. DMA pairing:
//     - Connect a dmactr on port 1 and a memory model; run a 4-word transfer.
//     - Memory contents match, eop_ asserts, and no `Write appears on the bus outside bus_busy.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus arbiter constants, state codes and helpers
package bus_arbiter_pkg;

  // Active-low request/grant levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Shared bus read/write encoding; the quiet bus always shows READ
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Index one past idx, wrapping at n
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side handshake and shared bus bundle
interface bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [N_MASTERS-1:0]        breq_;
  logic [N_MASTERS-1:0]        bgrt_;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_odata;
  logic [N_MASTERS-1:0]        m_rw_;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W-1:0]           odata;
  logic                        rw_;

  modport master (
    output breq_, m_addr, m_odata, m_rw_,
    input  bgrt_, addr, odata, rw_
  );

  modport slave (
    input  breq_, m_addr, m_odata, m_rw_,
    output bgrt_, addr, odata, rw_
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin priority selector
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] cand;

  // First active request scanning ptr, ptr+1, ... mod N_MASTERS; cand never exceeds N_MASTERS-1
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_MASTERS);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared bus arbiter with address/data mux
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = $clog2(N_MASTERS),
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_HOLD  = 256
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_if.slave     bus,
  output logic [IDX_W-1:0] owner,
  output logic             bus_busy,
  output logic             hold_ovf
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [N_MASTERS-1:0] gnt_n;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  bus_arbiter_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (~bus.breq_),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign bus.bgrt_ = gnt_n;

  // Arbitration FSM: grant in IDLE, hold without preemption, one dead cycle on release
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      gnt_n    <= '1;
      owner    <= '0;
      bus_busy <= 1'b0;
      hold_ovf <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state    <= ARB_GRANT;
            gnt_n    <= ~(N_MASTERS'(1) << pick_idx);
            owner    <= pick_idx;
            bus_busy <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (bus.breq_[owner] == DISABLE_) begin
            state    <= ARB_RELEASE;
            gnt_n    <= '1;
            bus_busy <= 1'b0;
            hold_ovf <= 1'b0;
            rr_ptr   <= IDX_W'(wrap_inc(int'(owner), N_MASTERS));
          end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
              hold_ovf <= 1'b1;
            end
          end
        end
        ARB_RELEASE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Shared bus follows the owner; quiet READ with zero address/data when un-owned
  always_comb begin
    bus.addr  = '0;
    bus.odata = '0;
    bus.rw_   = READ;
    if (bus_busy) begin
      bus.addr  = bus.m_addr[owner*ADDR_W +: ADDR_W];
      bus.odata = bus.m_odata[owner*DATA_W +: DATA_W];
      bus.rw_   = bus.m_rw_[owner];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] owner;
  logic       bus_busy;
  logic       hold_ovf;

  int n_cmp;
  int n_err;

  bus_arbiter_if #(.N_MASTERS(4), .ADDR_W(16), .DATA_W(16)) bus ();

  bus_arbiter #(
    .N_MASTERS (4),
    .IDX_W     (2),
    .ADDR_W    (16),
    .DATA_W    (16),
    .MAX_HOLD  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .owner    (owner),
    .bus_busy (bus_busy),
    .hold_ovf (hold_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input int m);
    logic [15:0] a;
    logic [15:0] d;
    logic [3:0]  g;
    logic        rw;
    a  = 16'(16'h0020 * (m + 1));
    d  = 16'(16'hD000 + m);
    g  = ~(4'b0001 << m);
    rw = (m % 2 == 1) ? WRITE : READ;
    check({tag, "_bgrt"},  32'(bus.bgrt_), 32'(g));
    check({tag, "_owner"}, 32'(owner),     32'(m));
    check({tag, "_busy"},  32'(bus_busy),  32'd1);
    check({tag, "_addr"},  32'(bus.addr),  32'(a));
    check({tag, "_odata"}, 32'(bus.odata), 32'(d));
    check({tag, "_rw"},    32'(bus.rw_),   32'(rw));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_bgrt"}, 32'(bus.bgrt_), 32'hF);
    check({tag, "_busy"}, 32'(bus_busy),  32'd0);
    check({tag, "_rw"},   32'(bus.rw_),   32'(READ));
    check({tag, "_addr"}, 32'(bus.addr),  32'd0);
  endtask

  // Un-owned bus must never show a write or a stray address
  always @(negedge clk) begin
    if (!bus_busy) begin
      check("quiet_bus", {15'd0, bus.rw_, bus.addr}, {15'd0, READ, 16'h0000});
    end
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.breq_      = 4'b1111;
    bus.m_addr     = {16'h0080, 16'h0060, 16'h0040, 16'h0020};
    bus.m_odata    = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    bus.m_rw_      = 4'b0101;
    tick();
    tick();
    check_quiet("rst");
    check("rst_owner", 32'(owner),    32'd0);
    check("rst_ovf",   32'(hold_ovf), 32'd0);
    reset = 1'b0;

    // Single master 1
    bus.breq_ = 4'b1101;
    tick();
    check_grant("single", 1);
    tick();
    check_grant("single_hold", 1);
    bus.breq_ = 4'b1111;
    tick();
    check_quiet("single_rel");
    tick();
    check_quiet("single_dead");
    tick();

    // Reset withdraws a grant held by master 2
    bus.breq_ = 4'b1011;
    tick();
    check_grant("pre_rst", 2);
    reset = 1'b1;
    tick();
    check_quiet("mid_rst");
    reset     = 1'b0;
    bus.breq_ = 4'b1111;
    tick();
    // rr_ptr back at 0: master 0 beats master 2
    bus.breq_ = 4'b1010;
    tick();
    check_grant("post_rst", 0);
    bus.breq_ = 4'b1111;
    tick();
    tick();

    // Round-robin from rr_ptr=0 with all four requesting
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    bus.breq_ = 4'b0000;
    for (int t = 0; t < 5; t++) begin
      tick();
      check_grant($sformatf("rr%0d", t), t % 4);
      tick();
      tick();
      check_grant($sformatf("rr%0d_c3", t), t % 4);
      bus.breq_ = 4'b0000 | (4'b0001 << (t % 4));
      tick();
      check_quiet($sformatf("rr%0d_rel", t));
      bus.breq_ = 4'b0000;
      tick();
      check_quiet($sformatf("rr%0d_idle", t));
    end
    bus.breq_ = 4'b1111;
    tick();
    tick();
    tick();

    // Wrap and skip: get rr_ptr=3 via master 2
    bus.breq_ = 4'b1011;
    tick();
    check_grant("to_ptr3", 2);
    bus.breq_ = 4'b1111;
    tick();
    bus.breq_ = 4'b0101;
    tick();
    tick();
    check_grant("wrap3", 3);
    bus.breq_ = 4'b1101;
    tick();
    tick();
    tick();
    check_grant("skip1", 1);
    // Master 1 re-requests during RELEASE; rr_ptr=2 favours master 2
    bus.breq_ = 4'b1111;
    tick();
    bus.breq_ = 4'b1001;
    tick();
    tick();
    check_grant("ptr2", 2);
    bus.breq_ = 4'b1101;
    tick();
    tick();
    tick();
    check_grant("ptr3_to1", 1);
    bus.breq_ = 4'b1111;
    tick();
    tick();
    tick();

    // No preemption, hold_ovf after the 8th grant cycle
    bus.breq_ = 4'b1110;
    tick();
    check_grant("hold", 0);
    check("hold_ovf0", 32'(hold_ovf), 32'd0);
    bus.breq_ = 4'b0110;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("hold%0d_bgrt", i), 32'(bus.bgrt_), 32'hE);
      check($sformatf("hold%0d_ovf", i),  32'(hold_ovf),  (i >= 8) ? 32'd1 : 32'd0);
    end
    bus.breq_ = 4'b0111;
    tick();
    check_quiet("hold_rel");
    check("hold_rel_ovf", 32'(hold_ovf), 32'd0);
    tick();
    check_quiet("hold_dead");
    tick();
    check_grant("after_hold", 3);
    bus.breq_ = 4'b1111;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
